// File: rtl/step_seq_decoder_if.sv
// Phase-bus interface for the full-step sequence decoder.
// The observer drives phase_in and clear; the decoder reports position and status.
interface step_seq_decoder_if #(
    parameter int POS_W = 16
);
    logic [3:0]              phase_in;
    logic                    clear;
    logic signed [POS_W-1:0] position;
    logic                    step_valid;
    logic                    dir;
    logic                    locked;
    logic                    error;

    modport master (
        output phase_in, clear,
        input  position, step_valid, dir, locked, error
    );

    modport slave (
        input  phase_in, clear,
        output position, step_valid, dir, locked, error
    );
endinterface

// File: rtl/step_seq_decoder.sv
// Receive-side decoder for the 0011->0110->1100->1001 full-step phase sequence:
// validates transitions, counts signed position and flags skipped or corrupted phases.
module step_seq_decoder #(
    parameter int POS_W      = 16,
    parameter int GLITCH_MAX = 2
) (
    input logic               clk,
    input logic               rst,
    step_seq_decoder_if.slave bus
);
    localparam int GW = $clog2(GLITCH_MAX + 2);

    typedef enum logic [1:0] {
        UNLOCKED,
        LOCKED,
        FAULT
    } state_t;

    state_t                  state, state_next;
    logic [3:0]              sync1, sync2;
    logic [1:0]              idx, idx_next;
    logic [GW-1:0]           glitch, glitch_next;
    logic signed [POS_W-1:0] pos_q, pos_next;
    logic                    dir_q, dir_next;
    logic                    step_q, step_next;
    logic                    code_legal;
    logic [1:0]              code_idx;
    logic [1:0]              delta;

    // phase_in is unrelated to clk, so it passes two flops before decode
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1  <= 4'b0000;
            sync2  <= 4'b0000;
            state  <= UNLOCKED;
            idx    <= 2'd0;
            glitch <= '0;
            pos_q  <= '0;
            dir_q  <= 1'b0;
            step_q <= 1'b0;
        end else begin
            sync1  <= bus.phase_in;
            sync2  <= sync1;
            state  <= state_next;
            idx    <= idx_next;
            glitch <= glitch_next;
            pos_q  <= pos_next;
            dir_q  <= dir_next;
            step_q <= step_next;
        end
    end

    always_comb begin
        code_legal = 1'b1;
        code_idx   = 2'd0;
        case (sync2)
            4'b0011: code_idx = 2'd0;
            4'b0110: code_idx = 2'd1;
            4'b1100: code_idx = 2'd2;
            4'b1001: code_idx = 2'd3;
            default: code_legal = 1'b0;
        endcase
    end

    // Modulo-4 distance from the stored phase: 1 forward, 3 reverse, 2 skipped
    always_comb begin
        state_next  = state;
        idx_next    = idx;
        glitch_next = glitch;
        pos_next    = pos_q;
        dir_next    = dir_q;
        step_next   = 1'b0;
        delta       = code_idx - idx;

        if (bus.clear) begin
            state_next  = UNLOCKED;
            pos_next    = '0;
            glitch_next = '0;
        end else begin
            case (state)
                UNLOCKED: begin
                    if (code_legal) begin
                        state_next = LOCKED;
                        idx_next   = code_idx;
                    end
                end
                LOCKED: begin
                    if (!code_legal) begin
                        if (int'(glitch) + 1 > GLITCH_MAX) begin
                            state_next = FAULT;
                        end else begin
                            glitch_next = glitch + GW'(1);
                        end
                    end else begin
                        glitch_next = '0;
                        case (delta)
                            2'd1: begin
                                pos_next  = pos_q + POS_W'(1);
                                dir_next  = 1'b1;
                                step_next = 1'b1;
                                idx_next  = code_idx;
                            end
                            2'd3: begin
                                pos_next  = pos_q - POS_W'(1);
                                dir_next  = 1'b0;
                                step_next = 1'b1;
                                idx_next  = code_idx;
                            end
                            2'd2: state_next = FAULT;
                            default: ;
                        endcase
                    end
                end
                FAULT: ;
                default: state_next = UNLOCKED;
            endcase
        end
    end

    assign bus.position   = pos_q;
    assign bus.step_valid = step_q;
    assign bus.dir        = dir_q;
    assign bus.locked     = (state == LOCKED);
    assign bus.error      = (state == FAULT);
endmodule

// File: tb/tb_step_seq_decoder.sv
// Scoreboard bench for step_seq_decoder: a reference model predicts every step event
// and status bit from the phase-sequence rules; a negedge monitor compares the DUT.
module tb_step_seq_decoder;
    localparam int POS_W      = 16;
    localparam int GLITCH_MAX = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    step_seq_decoder_if #(.POS_W(POS_W)) bus ();

    step_seq_decoder #(
        .POS_W      (POS_W),
        .GLITCH_MAX (GLITCH_MAX)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [POS_W-1:0] pos;
        logic             dir;
    } step_t;

    int               checks = 0;
    int               errors = 0;
    int               pulses = 0;
    step_t            sb_q[$];
    logic [3:0]       legal_codes[4] = '{4'b0011, 4'b0110, 4'b1100, 4'b1001};
    logic [3:0]       illegal_codes[$];
    logic [POS_W-1:0] pos_u;

    assign pos_u = bus.position;

    // Reference model state: mode 0 = unlocked, 1 = locked, 2 = fault
    int               m_mode   = 0;
    int               m_cur    = 0;
    int               m_glitch = 0;
    logic [POS_W-1:0] m_pos    = '0;
    logic             m_dir    = 1'b0;
    logic             m_step   = 1'b0;
    logic [3:0]       m_p1     = 4'b0000;
    logic [3:0]       m_p2     = 4'b0000;

    function automatic int code_index(input logic [3:0] c);
        for (int i = 0; i < 4; i++) begin
            if (legal_codes[i] == c) return i;
        end
        return -1;
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Caller is aligned on a falling edge; holds the code for the given cycles
    task automatic apply_stimulus(input logic [3:0] ph, input int cycles);
        bus.phase_in = ph;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic pulse_clear();
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
    endtask

    // Brings the decoder to a fresh lock on 0011 with position zero
    task automatic relock_at_zero();
        apply_stimulus(4'b0011, 3);
        pulse_clear();
        apply_stimulus(4'b0011, 4);
    endtask

    task automatic random_walk(input int iters);
        int cur;
        int r;
        cur = 0;
        relock_at_zero();
        for (int n = 0; n < iters; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 65) begin
                cur = (cur + (($urandom_range(0, 1) == 1) ? 1 : 3)) % 4;
                apply_stimulus(legal_codes[cur], int'($urandom_range(1, 3)));
            end else if (r < 82) begin
                apply_stimulus(illegal_codes[$urandom_range(0, 11)], int'($urandom_range(1, 4)));
            end else if (r < 90) begin
                cur = (cur + 2) % 4;
                apply_stimulus(legal_codes[cur], int'($urandom_range(1, 3)));
            end else begin
                pulse_clear();
            end
        end
    endtask

    // Decisions at an edge act on the code sampled two edges earlier
    initial begin
        int         k;
        int         d;
        logic [3:0] seen;
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                m_mode   = 0;
                m_cur    = 0;
                m_glitch = 0;
                m_pos    = '0;
                m_dir    = 1'b0;
                m_step   = 1'b0;
                m_p1     = 4'b0000;
                m_p2     = 4'b0000;
            end else begin
                seen   = m_p2;
                m_p2   = m_p1;
                m_p1   = bus.phase_in;
                k      = code_index(seen);
                m_step = 1'b0;
                if (bus.clear) begin
                    m_mode   = 0;
                    m_pos    = '0;
                    m_glitch = 0;
                end else if (m_mode == 0) begin
                    if (k >= 0) begin
                        m_mode = 1;
                        m_cur  = k;
                    end
                end else if (m_mode == 1) begin
                    if (k < 0) begin
                        m_glitch++;
                        if (m_glitch > GLITCH_MAX) m_mode = 2;
                    end else begin
                        m_glitch = 0;
                        d = (k - m_cur + 4) % 4;
                        if (d == 1 || d == 3) begin
                            m_pos  = (d == 1) ? m_pos + POS_W'(1) : m_pos - POS_W'(1);
                            m_dir  = (d == 1);
                            m_step = 1'b1;
                            m_cur  = k;
                            sb_q.push_back('{pos: m_pos, dir: m_dir});
                        end else if (d == 2) begin
                            m_mode = 2;
                        end
                    end
                end
            end
        end
    end

    initial begin
        step_t e;
        forever begin
            @(negedge clk);
            check_output("step_valid", 32'(bus.step_valid), 32'(m_step));
            check_output("position", 32'(pos_u), 32'(m_pos));
            check_output("dir", 32'(bus.dir), 32'(m_dir));
            check_output("locked", 32'(bus.locked), 32'(m_mode == 1));
            check_output("error", 32'(bus.error), 32'(m_mode == 2));
            if (bus.step_valid) begin
                pulses++;
                if (sb_q.size() == 0) begin
                    check_output("sb_unexpected_step", 32'(sb_q.size()), 32'd1);
                end else begin
                    e = sb_q.pop_front();
                    check_output("sb_step_pos", 32'(pos_u), 32'(e.pos));
                    check_output("sb_step_dir", 32'(bus.dir), 32'(e.dir));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int p0;
        for (int v = 0; v < 16; v++) begin
            if (code_index(4'(v)) < 0) illegal_codes.push_back(4'(v));
        end
        bus.phase_in = 4'b0000;
        bus.clear    = 1'b0;

        #1 rst = 1'b0;
        #1;
        check_output("reset_position", 32'(pos_u), 32'd0);
        check_output("reset_locked", 32'(bus.locked), 32'd0);
        check_output("reset_error", 32'(bus.error), 32'd0);
        check_output("reset_step_valid", 32'(bus.step_valid), 32'd0);
        check_output("reset_dir", 32'(bus.dir), 32'd0);
        #21 rst = 1'b1;
        @(negedge clk);

        $display("[TB] forward sequence");
        p0 = pulses;
        apply_stimulus(4'b0011, 2);
        check_output("lock_latency_early", 32'(bus.locked), 32'd0);
        apply_stimulus(4'b0011, 1);
        check_output("lock_latency_third", 32'(bus.locked), 32'd1);
        apply_stimulus(4'b0011, 1);
        apply_stimulus(4'b0110, 4);
        apply_stimulus(4'b1100, 4);
        apply_stimulus(4'b1001, 4);
        apply_stimulus(4'b0011, 4);
        check_output("fwd_position", 32'(pos_u), 32'd4);
        check_output("fwd_dir", 32'(bus.dir), 32'd1);
        check_output("fwd_error", 32'(bus.error), 32'd0);
        check_output("fwd_pulses", 32'(pulses - p0), 32'd4);

        $display("[TB] reverse sequence");
        pulse_clear();
        apply_stimulus(4'b0011, 4);
        p0 = pulses;
        apply_stimulus(4'b1001, 4);
        apply_stimulus(4'b1100, 4);
        apply_stimulus(4'b0110, 4);
        check_output("rev_position", 32'(pos_u), 32'h0000_FFFD);
        check_output("rev_dir", 32'(bus.dir), 32'd0);
        check_output("rev_pulses", 32'(pulses - p0), 32'd3);

        $display("[TB] skipped phase");
        relock_at_zero();
        apply_stimulus(4'b1100, 4);
        check_output("skip_error", 32'(bus.error), 32'd1);
        check_output("skip_locked", 32'(bus.locked), 32'd0);
        check_output("skip_position", 32'(pos_u), 32'd0);
        for (int i = 0; i < 8; i++) apply_stimulus(legal_codes[(i + 3) % 4], 1);
        apply_stimulus(4'b0000, 3);
        check_output("fault_sticky", 32'(bus.error), 32'd1);
        check_output("fault_position", 32'(pos_u), 32'd0);
        pulse_clear();
        check_output("clear_error", 32'(bus.error), 32'd0);
        check_output("clear_locked", 32'(bus.locked), 32'd0);
        apply_stimulus(4'b0000, 3);
        check_output("clear_unlocked", 32'(bus.locked), 32'd0);

        $display("[TB] glitch tolerance");
        relock_at_zero();
        apply_stimulus(4'b0111, 2);
        apply_stimulus(4'b0110, 4);
        check_output("glitch2_position", 32'(pos_u), 32'd1);
        check_output("glitch2_error", 32'(bus.error), 32'd0);
        apply_stimulus(4'b0111, 3);
        apply_stimulus(4'b1100, 4);
        check_output("glitch3_error", 32'(bus.error), 32'd1);
        check_output("glitch3_position", 32'(pos_u), 32'd1);

        $display("[TB] position wrap");
        relock_at_zero();
        for (int i = 1; i <= 32767; i++) apply_stimulus(legal_codes[i % 4], 1);
        apply_stimulus(legal_codes[3], 2);
        check_output("preload_position", 32'(pos_u), 32'h0000_7FFF);
        apply_stimulus(legal_codes[0], 4);
        check_output("wrap_position", 32'(pos_u), 32'h0000_8000);

        $display("[TB] clear against step");
        apply_stimulus(4'b0110, 2);
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        check_output("clear_step_position", 32'(pos_u), 32'd0);
        check_output("clear_step_valid", 32'(bus.step_valid), 32'd0);
        apply_stimulus(4'b0110, 3);
        check_output("clear_step_relock", 32'(bus.locked), 32'd1);

        $display("[TB] random walk");
        random_walk(400);

        $display("[TB] reset mid-sequence");
        relock_at_zero();
        apply_stimulus(4'b0110, 2);
        apply_stimulus(4'b1100, 2);
        apply_stimulus(4'b1001, 2);
        apply_stimulus(4'b0011, 2);
        apply_stimulus(4'b0110, 4);
        check_output("pre_reset_position", 32'(pos_u), 32'd5);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check_output("async_position", 32'(pos_u), 32'd0);
        check_output("async_locked", 32'(bus.locked), 32'd0);
        check_output("async_step_valid", 32'(bus.step_valid), 32'd0);
        check_output("async_dir", 32'(bus.dir), 32'd0);
        check_output("async_error", 32'(bus.error), 32'd0);
        @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        apply_stimulus(4'b0110, 5);
        check_output("post_reset_locked", 32'(bus.locked), 32'd1);
        check_output("post_reset_position", 32'(pos_u), 32'd0);

        apply_stimulus(4'b0110, 2);
        check_output("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
